// File: rtl/mul_seq_ctrl_pkg.sv
// Shared widths, FSM encodings and the full-adder cell
// for the sequential shift-add multiplier.
package mul_seq_ctrl_pkg;

    localparam int DATA_BUS_WIDTH = 32;
    localparam int MUL_CNT_W      = 5;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    // Returns {carry_out, sum} of one full-adder cell.
    function automatic logic [1:0] full_adder(
        input logic a,
        input logic b,
        input logic ci
    );
        logic s;
        logic co;
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
        return {co, s};
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_rca.sv
// W-bit ripple-carry adder built from a chain of
// full-adder cells; the multiplier's only adder.
module rca
    import mul_seq_ctrl_pkg::*;
#(
    parameter int W = DATA_BUS_WIDTH
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    always_comb begin
        logic       c;
        logic [1:0] r;
        c     = cin_i;
        r     = '0;
        sum_o = '0;
        for (int i = 0; i < W; i++) begin
            r        = full_adder(a_i[i], b_i[i], c);
            sum_o[i] = r[0];
            c        = r[1];
        end
        cout_o = c;
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier for the EX stage:
// one adder iteration per cycle, start/busy/valid handshake.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_BUS_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    localparam int PW = 2 * WIDTH;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;

    logic [WIDTH-1:0] op1_mag;
    logic [WIDTH-1:0] op2_mag;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             acc_c;
    logic [PW-1:0]    acc_nxt;
    logic [PW-1:0]    prod;

    // -2^(W-1) maps to 2^(W-1), which fits unsigned W bits.
    assign op1_mag = (sign_mode && op1[WIDTH-1])
                   ? (~op1 + WIDTH'(1)) : op1;
    assign op2_mag = (sign_mode && op2[WIDTH-1])
                   ? (~op2 + WIDTH'(1)) : op2;

    assign addend = acc_lo_q[0] ? mcand_q : '0;

    rca #(
        .W(WIDTH)
    ) u_rca (
        .a_i   (acc_hi_q),
        .b_i   (addend),
        .cin_i (1'b0),
        .sum_o (sum),
        .cout_o(acc_c)
    );

    // {acc_c, sum, acc_lo} >> 1: the carry lands in the top bit.
    assign acc_nxt = {acc_c, sum, acc_lo_q[WIDTH-1:1]};
    assign prod    = neg_q ? (~acc_nxt + PW'(1)) : acc_nxt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        neg_d    = neg_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        unique case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    mcand_d  = op1_mag;
                    acc_lo_d = op2_mag;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    neg_d    = sign_mode
                             & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                acc_hi_d = acc_nxt[PW-1:WIDTH];
                acc_lo_d = acc_nxt[WIDTH-1:0];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_hi_d = prod[PW-1:WIDTH];
                    res_lo_d = prod[WIDTH-1:0];
                    state_d  = MUL_DONE;
                end
            end
            MUL_DONE: begin
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
        // Abort beats everything, including a same-cycle start.
        if (flush) begin
            state_d  = MUL_IDLE;
            cnt_d    = '0;
            mcand_d  = mcand_q;
            acc_hi_d = acc_hi_q;
            acc_lo_d = acc_lo_q;
            neg_d    = neg_q;
            res_hi_d = res_hi_q;
            res_lo_d = res_lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            neg_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            neg_q    <= neg_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    assign busy      = (state_q != MUL_IDLE);
    assign out_valid = (state_q == MUL_DONE);
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: hand-computed products,
// latency, flush/reset aborts and back-to-back issue.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        start;
    logic        sign_mode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        out_valid;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int n_pass;
    int n_total;

    mul_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .start    (start),
        .sign_mode(sign_mode),
        .op1      (op1),
        .op2      (op2),
        .busy     (busy),
        .out_valid(out_valid),
        .result_hi(result_hi),
        .result_lo(result_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op and returns at the negedge where out_valid
    // is seen (or after a bounded wait).
    task automatic run_op(
        input  logic        s,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output int          nbusy,
        output logic        got
    );
        @(negedge clk);
        start = 1'b1; sign_mode = s; op1 = a; op2 = b;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        got   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (busy) nbusy++;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if ({busy, out_valid, result_hi, result_lo} !== '0)
            $display("FAIL reset: got %b %b %h %h want 0 0 0 0",
                     busy, out_valid, result_hi, result_lo);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_product(
        input string       name,
        input logic        s,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] ehi,
        input logic [31:0] elo
    );
        int   nb;
        logic got;
        run_op(s, a, b, nb, got);
        n_total++;
        if (got !== 1'b1 || nb != 33)
            $display("FAIL %s_latency: valid=%b busy_cycles=%0d want 1 33",
                     name, got, nb);
        else n_pass++;
        n_total++;
        if (result_hi !== ehi || result_lo !== elo)
            $display("FAIL %s: got %h_%h want %h_%h",
                     name, result_hi, result_lo, ehi, elo);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 ||
            result_hi !== ehi || result_lo !== elo)
            $display("FAIL %s_after: got v=%b b=%b %h_%h want 0 0 %h_%h",
                     name, out_valid, busy, result_hi, result_lo,
                     ehi, elo);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        logic got;
        @(negedge clk);
        start = 1'b1; sign_mode = 1'b0; op1 = 32'd100; op2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; sign_mode = 1'b1; op1 = 32'd50; op2 = 32'd50;
        repeat (2) @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_total++;
        if (got !== 1'b1 || result_hi !== 32'd0 || result_lo !== 32'd300)
            $display("FAIL busy_start_ignored: v=%b %h_%h want 1 0_12c",
                     got, result_hi, result_lo);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic seen;
        @(negedge clk);
        start = 1'b1; sign_mode = 1'b0; op1 = 32'd9; op2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_total++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL flush_idle: busy=%b valid=%b want 0 0",
                     busy, out_valid);
        else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_total++;
        if (seen !== 1'b0 || result_hi !== 32'h40000000 ||
            result_lo !== 32'd0)
            $display("FAIL flush_no_result: v=%b %h_%h want 0 40000000_0",
                     seen, result_hi, result_lo);
        else n_pass++;
        flush = 1'b1; start = 1'b1; op1 = 32'd2; op2 = 32'd2;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL flush_beats_start: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   nb;
        int   cyc;
        logic got;
        run_op(1'b0, 32'd7, 32'd6, nb, got);
        n_total++;
        if (got !== 1'b1 || result_lo !== 32'd42)
            $display("FAIL b2b_first: v=%b lo=%h want 1 2a", got, result_lo);
        else n_pass++;
        // Held from DONE: ignored there, accepted in the IDLE cycle.
        start = 1'b1; sign_mode = 1'b0; op1 = 32'd11; op2 = 32'd13;
        @(negedge clk);
        cyc = 1;
        @(negedge clk);
        cyc = 2;
        start = 1'b0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_total++;
        if (cyc != 34 || result_hi !== 32'd0 || result_lo !== 32'd143)
            $display("FAIL b2b_second: gap=%0d %h_%h want 34 0_8f",
                     cyc, result_hi, result_lo);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int   nb;
        logic got;
        @(negedge clk);
        start = 1'b1; sign_mode = 1'b0; op1 = 32'd7; op2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, out_valid, result_hi, result_lo} !== '0)
            $display("FAIL async_reset: got %b %b %h %h want 0 0 0 0",
                     busy, out_valid, result_hi, result_lo);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 32'd7, 32'd6, nb, got);
        n_total++;
        if (got !== 1'b1 || nb != 33 || result_lo !== 32'd42)
            $display("FAIL reset_recover: v=%b n=%0d lo=%h want 1 33 2a",
                     got, nb, result_lo);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; flush = 1'b0; start = 1'b0;
        sign_mode = 1'b0; op1 = '0; op2 = '0;
        test_reset();
        test_product("u_7x6", 1'b0, 32'd7, 32'd6,
                     32'h0, 32'd42);
        test_product("u_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32'h00000001);
        test_product("s_m3x5", 1'b1, 32'hFFFFFFFD, 32'd5,
                     32'hFFFFFFFF, 32'hFFFFFFF1);
        test_product("s_7xm6", 1'b1, 32'd7, 32'hFFFFFFFA,
                     32'hFFFFFFFF, 32'hFFFFFFD6);
        test_product("u_msb", 1'b0, 32'hFFFFFFFD, 32'd5,
                     32'h00000004, 32'hFFFFFFF1);
        test_product("zero", 1'b0, 32'd0, 32'h12345678,
                     32'h0, 32'h0);
        test_product("s_min", 1'b1, 32'h80000000, 32'h80000000,
                     32'h40000000, 32'h0);
        test_flush();
        test_start_while_busy();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
